// File: rtl/microwire_master.sv
// Microwire (93xx EEPROM) host: serializes one command on CS/SK/DI, captures read data, polls busy.
// Latency: frame length x 2*CLK_DIV clk plus gap/poll time; accepts a new command only when idle.
module microwire_master #(
  parameter int CLK_DIV  = 4,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int CS_GAP   = 8,
  parameter int POLL_MAX = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ee_cs,
  output logic              ee_sk,
  output logic              ee_di,
  input  logic              ee_do
);

  localparam int CMD_W   = 3 + ADDR_W;
  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int TMR_W   = $clog2(((POLL_MAX > CS_GAP) ? POLL_MAX : CS_GAP) + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(CMD_W - 1);
  localparam logic [BIT_W-1:0] FRM_LAST  = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] DAT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(CS_GAP - 1);
  localparam logic [TMR_W-1:0] POLL_LAST = TMR_W'(POLL_MAX - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_DUMMY,
    S_RECV,
    S_GAP,
    S_POLL,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                hi_q, hi_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [FRAME_W-1:0]  sh_q, sh_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [1:0]          op_q, op_d;
  logic [1:0]          ext_q, ext_d;
  logic                cs_q, cs_d;
  logic                sk_q, sk_d;
  logic                di_q, di_d;
  logic                do_s1_q, do_s2_q;

  logic                is_read;
  logic                has_data;
  logic                no_poll;
  logic                bit_end;
  logic                sk_active;
  logic [BIT_W-1:0]    last_bit;

  assign is_read  = (op_q == 2'b10);
  assign has_data = (op_q == 2'b01) || ((op_q == 2'b00) && (ext_q == 2'b01));
  assign no_poll  = (op_q == 2'b00) && ((ext_q == 2'b11) || (ext_q == 2'b00));
  assign last_bit = has_data ? FRM_LAST : CMD_LAST;
  // Last clk of an SK-high phase: the EEPROM's DO is sampled and the bit advances.
  assign bit_end  = hi_q && (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    hi_d      = hi_q;
    bit_d     = bit_q;
    tmr_d     = tmr_q;
    sh_d      = sh_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    op_d      = op_q;
    ext_d     = ext_q;
    sk_active = (state_q == S_SEND) || (state_q == S_DUMMY) || (state_q == S_RECV);

    if (sk_active) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        hi_d  = ~hi_q;
      end else begin
        div_d = div_q + DIV_ONE;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_SEND;
          sh_d    = {1'b1, cmd_op, cmd_addr, cmd_wdata};
          op_d    = cmd_op;
          ext_d   = cmd_addr[ADDR_W-1 -: 2];
          err_d   = 1'b0;
          div_d   = '0;
          hi_d    = 1'b0;
          bit_d   = '0;
        end
      end
      S_SEND: begin
        if (bit_end) begin
          if (bit_q == last_bit) begin
            bit_d = '0;
            tmr_d = '0;
            if (is_read)      state_d = S_DUMMY;
            else if (no_poll) state_d = S_DONE;
            else              state_d = S_GAP;
          end else begin
            bit_d = bit_q + BIT_ONE;
            sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      S_DUMMY: begin
        if (bit_end) begin
          if (do_s2_q) err_d = 1'b1;
          state_d = S_RECV;
          bit_d   = '0;
        end
      end
      S_RECV: begin
        if (bit_end) begin
          rx_d = {rx_q[DATA_W-2:0], do_s2_q};
          if (bit_q == DAT_LAST) begin
            state_d = S_DONE;
            rdata_d = {rx_q[DATA_W-2:0], do_s2_q};
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      S_GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = S_POLL;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      S_POLL: begin
        if (do_s2_q) begin
          state_d = S_DONE;
        end else if (tmr_q == POLL_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pins are registered from next-state so they stay glitch-free and aligned with the FSM.
    cs_d = (state_d == S_SEND) || (state_d == S_DUMMY) || (state_d == S_RECV) ||
           (state_d == S_POLL);
    sk_d = ((state_d == S_SEND) || (state_d == S_DUMMY) || (state_d == S_RECV)) && hi_d;
    di_d = (state_d == S_SEND) && sh_d[FRAME_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      hi_q    <= 1'b0;
      bit_q   <= '0;
      tmr_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      op_q    <= 2'b00;
      ext_q   <= 2'b00;
      cs_q    <= 1'b0;
      sk_q    <= 1'b0;
      di_q    <= 1'b0;
      do_s1_q <= 1'b0;
      do_s2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      bit_q   <= bit_d;
      tmr_q   <= tmr_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      op_q    <= op_d;
      ext_q   <= ext_d;
      cs_q    <= cs_d;
      sk_q    <= sk_d;
      di_q    <= di_d;
      do_s1_q <= ee_do;
      do_s2_q <= do_s1_q;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign ee_cs     = cs_q;
  assign ee_sk     = sk_q;
  assign ee_di     = di_q;

endmodule
